// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with valid/ready handshake, flush-to-bubble and a saturating stall counter.
// Latency 1 cycle; `ID_EX_SKID_EN adds a skid entry so in_ready is registered (no path from out_ready).
module id_ex_pipe_reg #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CTL_W  = 10,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTL_W-1:0]  in_ctl,
   input  logic [REG_AW-1:0] in_rt,
   input  logic [REG_AW-1:0] in_rd,
   input  logic [DATA_W-1:0] in_imm,
   input  logic [DATA_W-1:0] in_pc,
   input  logic [DATA_W-1:0] in_rd1,
   input  logic [DATA_W-1:0] in_rd2,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              RegDst,
   output logic              ALUSrc,
   output logic              Branch,
   output logic [1:0]        ALUOp,
   output logic [CTL_W-6:0]  out_ctl,
   output logic [REG_AW-1:0] out_rt,
   output logic [REG_AW-1:0] out_rd,
   output logic [DATA_W-1:0] out_imm,
   output logic [DATA_W-1:0] out_pc,
   output logic [DATA_W-1:0] out_rd1,
   output logic [DATA_W-1:0] out_rd2,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef struct packed {
      logic [CTL_W-1:0]  ctl;
      logic [REG_AW-1:0] rt;
      logic [REG_AW-1:0] rd;
      logic [DATA_W-1:0] imm;
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] rd1;
      logic [DATA_W-1:0] rd2;
   } ent_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   ent_t             w_in;
   ent_t             r_out;
   logic             r_out_vld;
   logic             w_accept;
   logic             w_consume;
   logic [CNT_W-1:0] r_stall_cnt;

   assign w_in      = {in_ctl, in_rt, in_rd, in_imm, in_pc, in_rd1, in_rd2};
   assign w_consume = r_out_vld & out_ready;

`ifdef ID_EX_SKID_EN
   ent_t r_skid;
   logic r_skid_vld;

   assign in_ready = ~r_skid_vld;
   assign w_accept = in_valid & ~r_skid_vld;

   // Skid is only ever occupied behind a valid output entry, so order is output then skid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out      <= '0;
         r_out_vld  <= 1'b0;
         r_skid     <= '0;
         r_skid_vld <= 1'b0;
      end else if (flush) begin
         r_out_vld  <= 1'b0;
         r_out.ctl  <= '0;
         r_skid_vld <= 1'b0;
      end else if (r_skid_vld) begin
         if (w_consume) begin
            r_out      <= r_skid;
            r_skid_vld <= 1'b0;
         end
      end else if (w_accept) begin
         if (!r_out_vld || w_consume) begin
            r_out     <= w_in;
            r_out_vld <= 1'b1;
         end else begin
            r_skid     <= w_in;
            r_skid_vld <= 1'b1;
         end
      end else if (w_consume) begin
         r_out_vld <= 1'b0;
         r_out.ctl <= '0;
      end
   end
`else
   assign in_ready = ~r_out_vld | out_ready;
   assign w_accept = in_valid & in_ready;

   // Control is zeroed whenever the entry dies so a bubble can never write or branch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out     <= '0;
         r_out_vld <= 1'b0;
      end else if (flush) begin
         r_out_vld <= 1'b0;
         r_out.ctl <= '0;
      end else if (w_accept) begin
         r_out     <= w_in;
         r_out_vld <= 1'b1;
      end else if (w_consume) begin
         r_out_vld <= 1'b0;
         r_out.ctl <= '0;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
      end else if (r_out_vld && !out_ready && !(&r_stall_cnt)) begin
         r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
   end

   assign out_valid = r_out_vld;
   assign RegDst    = r_out.ctl[CTL_W-1];
   assign ALUSrc    = r_out.ctl[CTL_W-2];
   assign ALUOp     = r_out.ctl[CTL_W-3 -: 2];
   assign Branch    = r_out.ctl[CTL_W-5];
   assign out_ctl   = r_out.ctl[CTL_W-6:0];
   assign out_rt    = r_out.rt;
   assign out_rd    = r_out.rd;
   assign out_imm   = r_out.imm;
   assign out_pc    = r_out.pc;
   assign out_rd1   = r_out.rd1;
   assign out_rd2   = r_out.rd2;
   assign stall_cnt = r_stall_cnt;

endmodule
